// File: rtl/lane_packer_pkg.sv
// Shared definitions for the lane packer.
// Holds the control FSM state encodings and a constant clog2 helper
// used to size the lane counter and the N output.
package lane_packer_pkg;

   // Control FSM states; the output-valid flag is kept outside the FSM.
   typedef enum logic [1:0] {
      ST_EMPTY     = 2'd0,   // no lanes collected, no flush pending
      ST_FILL      = 2'd1,   // partial word being collected
      ST_FLUSHWAIT = 2'd2    // flush requested, output register still busy
   } state_t;

   // Ceiling log2 for constant sizing; clog2(1)=0, clog2(3)=2.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            r = i + 1;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/lane_packer_and_reduce_tree.sv
// and_reduce_tree: masked AND reduction.
// Bits whose mask bit is 0 are forced to 1 so they do not affect the result.
//   data : word to reduce
//   mask : 1 = bit takes part in the reduction
//   z    : AND of all masked-in bits of data
module and_reduce_tree
   import lane_packer_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] data,
   input  logic [W-1:0] mask,
   output logic         z
);

   // Masked-out bits read as 1 so only selected bits decide the result.
   always_comb begin
      z = &(data | ~mask);
   end

endmodule

// File: rtl/lane_packer.sv
// lane_packer: collects LANES input lanes of LANE_W bits into one wide word
// (lane 0 in the LSBs) and presents it on a valid/ready output register.
// A flush request emits the current partial word with FILL in empty lanes.
//   CLK, RST : clock, synchronous active-high reset
//   D, DV, DR: input lane, valid, ready (lane accepted when DV && DR)
//   FLUSH    : one-cycle request to emit the current partial word
//   Q, QV, QR: packed word, valid, downstream ready
//   Z        : AND of the filled-lane bits of Q (0 when QV=0)
//   T        : 1 = Q is a flushed partial word
//   N        : number of filled lanes in Q
module lane_packer
   import lane_packer_pkg::*;
#(
   parameter int   LANE_W = 4,
   parameter int   LANES  = 2,
   parameter logic FILL   = 1'b0,
   localparam int  OW     = LANE_W * LANES,
   localparam int  NW     = clog2(LANES + 1)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [LANE_W-1:0] D,
   input  logic              DV,
   output logic              DR,
   input  logic              FLUSH,
   output logic [OW-1:0]     Q,
   output logic              QV,
   input  logic              QR,
   output logic              Z,
   output logic              T,
   output logic [NW-1:0]     N
);

   localparam logic [NW-1:0] LAST = NW'(LANES - 1);

   state_t          state_r, state_s;
   logic [NW-1:0]   cnt_r, cnt_s;
   logic [OW-1:0]   acc_r, acc_s;
   logic [OW-1:0]   q_r;
   logic            qv_r, z_r, t_r;
   logic [NW-1:0]   n_r;

   logic            or_free_s, dr_s, take_s, complete_s;
   logic            fp_s, flush_go_s, load_s, fp_next_s, z_s;
   logic [NW-1:0]   cnt_eff_s;
   logic [OW-1:0]   acc_next_s, word_s, mask_s;

   // Handshake, lane insertion and candidate output word.
   always_comb begin
      or_free_s  = !qv_r || QR;
      // Only the completing lane has to wait for the output register.
      dr_s       = !RST && ((cnt_r < LAST) || or_free_s);
      take_s     = DV && dr_s;
      cnt_eff_s  = cnt_r + {{(NW-1){1'b0}}, take_s};
      complete_s = take_s && (cnt_r == LAST);
      fp_s       = (state_r == ST_FLUSHWAIT);
      // A completing lane always wins over a flush: the word is full anyway.
      flush_go_s = (fp_s || FLUSH) && or_free_s && (cnt_eff_s != {NW{1'b0}}) && !complete_s;
      load_s     = complete_s || flush_go_s;
      acc_next_s = acc_r;
      word_s     = {OW{1'b0}};
      mask_s     = {OW{1'b0}};
      for (int i = 0; i < LANES; i++) begin
         if (take_s && (cnt_r == NW'(i))) begin
            acc_next_s[i*LANE_W +: LANE_W] = D;
         end else begin
            acc_next_s[i*LANE_W +: LANE_W] = acc_r[i*LANE_W +: LANE_W];
         end
         if (NW'(i) < cnt_eff_s) begin
            mask_s[i*LANE_W +: LANE_W] = {LANE_W{1'b1}};
            word_s[i*LANE_W +: LANE_W] = acc_next_s[i*LANE_W +: LANE_W];
         end else begin
            mask_s[i*LANE_W +: LANE_W] = {LANE_W{1'b0}};
            word_s[i*LANE_W +: LANE_W] = {LANE_W{FILL}};
         end
      end
   end

   // Next lane count, accumulator, pending-flush flag and FSM state.
   always_comb begin
      // A flush with nothing collected (even counting this cycle's lane) is dropped.
      fp_next_s = !load_s && (fp_s || FLUSH) && (cnt_eff_s != {NW{1'b0}});
      if (load_s) begin
         cnt_s = {NW{1'b0}};
         acc_s = {OW{1'b0}};
      end else begin
         cnt_s = cnt_eff_s;
         acc_s = acc_next_s;
      end
      if (fp_next_s) begin
         state_s = ST_FLUSHWAIT;
      end else if (cnt_s != {NW{1'b0}}) begin
         state_s = ST_FILL;
      end else begin
         state_s = ST_EMPTY;
      end
   end

   and_reduce_tree #(.W(OW)) u_zred (
      .data (word_s),
      .mask (mask_s),
      .z    (z_s)
   );

   // Control registers: FSM state, lane count and accumulator.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= ST_EMPTY;
         cnt_r   <= {NW{1'b0}};
         acc_r   <= {OW{1'b0}};
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         acc_r   <= acc_s;
      end
   end

   // Output register: load a word, clear valid on consume, otherwise hold.
   always_ff @(posedge CLK) begin
      if (RST) begin
         q_r  <= {OW{1'b0}};
         qv_r <= 1'b0;
         z_r  <= 1'b0;
         t_r  <= 1'b0;
         n_r  <= {NW{1'b0}};
      end else if (load_s) begin
         q_r  <= word_s;
         qv_r <= 1'b1;
         z_r  <= z_s;
         t_r  <= flush_go_s;
         n_r  <= cnt_eff_s;
      end else if (QR) begin
         // Consumed (or already idle): Q keeps its last value, Z follows QV.
         qv_r <= 1'b0;
         z_r  <= 1'b0;
      end else begin
         qv_r <= qv_r;
      end
   end

   assign DR = dr_s;
   assign Q  = q_r;
   assign QV = qv_r;
   assign Z  = z_r;
   assign T  = t_r;
   assign N  = n_r;

endmodule
